// File: rtl/wilton_cfg_loader.sv
// Framed configuration loader for NUM_SW Wilton switches: shadow assembly, atomic commit.
// Define WILTON_CFG_CRC_EN to require a trailing CRC-16-CCITT word over header and data.
module wilton_cfg_loader #(
    parameter int NUM_SW = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [15:0]           in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  abort,
    output logic [NUM_SW*16-1:0]  sw_desig,
    output logic [NUM_SW*32-1:0]  sw_route,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [1:0]            err_code
);

`ifdef WILTON_CFG_CRC_EN
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CRC, S_COMMIT} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMMIT} state_t;
`endif

    localparam logic [15:0] HDR     = {8'hA5, 8'(NUM_SW)};
    localparam logic [7:0]  LAST_SW = 8'(NUM_SW - 1);

    state_t                 r_state;
    state_t                 w_next;
    logic [7:0]             r_sw;
    logic [1:0]             r_slot;
    logic [NUM_SW*16-1:0]   r_shd_desig;
    logic [NUM_SW*32-1:0]   r_shd_route;
    logic [NUM_SW*16-1:0]   r_desig;
    logic [NUM_SW*32-1:0]   r_route;
    logic [NUM_SW*16-1:0]   w_desig_nxt;
    logic [NUM_SW*32-1:0]   w_route_nxt;
    logic                   r_err;
    logic [1:0]             r_err_code;

    logic w_xfer, w_hdr_ok, w_hdr_bad, w_load, w_last, w_abort, w_commit;

    assign w_xfer    = in_valid && in_ready;
    assign w_hdr_ok  = (r_state == S_IDLE) && w_xfer && (in_data == HDR);
    assign w_hdr_bad = (r_state == S_IDLE) && w_xfer && (in_data != HDR);
    assign w_load    = (r_state == S_LOAD) && w_xfer;
    assign w_last    = (r_sw == LAST_SW) && (r_slot == 2'd2);

`ifdef WILTON_CFG_CRC_EN
    logic [15:0] r_crc;
    logic        w_crc_chk, w_crc_ok, w_crc_bad;

    // CRC-16-CCITT (0x1021), MSB first, one 16-bit word per call
    function automatic logic [15:0] crc16_word(input logic [15:0] c, input logic [15:0] d);
        logic [15:0] x;
        x = c;
        for (int unsigned i = 0; i < 16; i++) begin
            if (x[15] ^ d[15 - i]) x = {x[14:0], 1'b0} ^ 16'h1021;
            else                   x = {x[14:0], 1'b0};
        end
        return x;
    endfunction

    assign w_abort   = abort && ((r_state == S_LOAD) || (r_state == S_CRC));
    assign w_crc_chk = (r_state == S_CRC) && w_xfer;
    assign w_crc_ok  = w_crc_chk && (in_data == r_crc);
    assign w_crc_bad = w_crc_chk && (in_data != r_crc);
    assign w_commit  = w_crc_ok;
`else
    assign w_abort   = abort && (r_state == S_LOAD);
    assign w_commit  = w_load && w_last;
`endif

    // Live view of the shadow including this cycle's word, so the commit edge can take the last word directly
    always_comb begin
        w_desig_nxt = r_shd_desig;
        w_route_nxt = r_shd_route;
        if (w_load) begin
            case (r_slot)
                2'd0:    w_desig_nxt[{r_sw, 4'b0000} +: 16]        = in_data;
                2'd1:    w_route_nxt[{r_sw, 5'b00000} +: 16]       = in_data;
                default: w_route_nxt[{r_sw, 5'b00000} + 16 +: 16]  = in_data;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_hdr_ok) w_next = S_LOAD;
            S_LOAD: begin
                if (w_abort) w_next = S_IDLE;
`ifdef WILTON_CFG_CRC_EN
                else if (w_load && w_last) w_next = S_CRC;
`else
                else if (w_load && w_last) w_next = S_COMMIT;
`endif
            end
`ifdef WILTON_CFG_CRC_EN
            S_CRC: begin
                if (w_abort)        w_next = S_IDLE;
                else if (w_crc_ok)  w_next = S_COMMIT;
                else if (w_crc_bad) w_next = S_IDLE;
            end
`endif
            S_COMMIT: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        busy     = (r_state != S_IDLE);
        done     = (r_state == S_COMMIT);
        case (r_state)
            S_IDLE:   in_ready = !reset;
            S_LOAD:   in_ready = !reset && !abort;
`ifdef WILTON_CFG_CRC_EN
            S_CRC:    in_ready = !reset && !abort;
`endif
            default:  in_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sw        <= '0;
            r_slot      <= '0;
            r_shd_desig <= '0;
            r_shd_route <= '0;
            r_desig     <= '0;
            r_route     <= '0;
            r_err       <= 1'b0;
            r_err_code  <= '0;
`ifdef WILTON_CFG_CRC_EN
            r_crc       <= '0;
`endif
        end else begin
            r_err <= 1'b0;
            if (w_hdr_bad) begin
                r_err      <= 1'b1;
                r_err_code <= 2'd1;
            end
            if (w_abort) begin
                r_err      <= 1'b1;
                r_err_code <= 2'd3;
            end
`ifdef WILTON_CFG_CRC_EN
            if (w_crc_bad) begin
                r_err      <= 1'b1;
                r_err_code <= 2'd2;
            end
`endif
            if (w_hdr_ok) begin
                r_sw   <= '0;
                r_slot <= '0;
`ifdef WILTON_CFG_CRC_EN
                r_crc  <= crc16_word(16'hFFFF, in_data);
`endif
            end
            if (w_load) begin
                r_shd_desig <= w_desig_nxt;
                r_shd_route <= w_route_nxt;
                if (r_slot == 2'd2) begin
                    r_slot <= '0;
                    r_sw   <= r_sw + 8'd1;
                end else begin
                    r_slot <= r_slot + 2'd1;
                end
`ifdef WILTON_CFG_CRC_EN
                r_crc <= crc16_word(r_crc, in_data);
`endif
            end
            if (w_commit) begin
                r_desig <= w_desig_nxt;
                r_route <= w_route_nxt;
            end
        end
    end

    assign sw_desig = r_desig;
    assign sw_route = r_route;
    assign err      = r_err;
    assign err_code = r_err_code;

endmodule
